regfile_sequencer: RTL

- Micro-sequencer that owns the control side of the 4-entry, 16-bit, dual-read register file.
- Accepts one register-to-register operation per valid/ready handshake.
- Drives the file's address and write-select lines, captures operands and computes the result. Writes it back and pulses done.
- Guarantees the file is never read and written in the same cycle: its read outputs go high-Z while any write bit is set.

---
 rtl/regfile_seq_pkg.sv | 31 +++
 rtl/seq_alu.sv | 38 +++
 rtl/regfile_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared types and defaults for the register-file micro-sequencer
package regfile_seq_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned ABITS_DEF = 2;

  typedef enum logic [2:0] {
    OP_MOV  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_LDI  = 3'd6,
    OP_XCHG = 3'd7
  } op_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WR1  = 2'd2,
    ST_WR2  = 2'd3
  } state_e;

  // Only the arithmetic/logic codes touch the flags.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - combinational write-data and carry/borrow generation for the sequencer
module seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] wdata,
  output logic             carry
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  // The extra top bit is the carry-out for ADD and the borrow for SUB.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    wdata = '0;
    carry = 1'b0;
    case (op)
      OP_MOV:  wdata = b;
      OP_ADD:  begin wdata = sum_ext[WIDTH-1:0];  carry = sum_ext[WIDTH];  end
      OP_SUB:  begin wdata = diff_ext[WIDTH-1:0]; carry = diff_ext[WIDTH]; end
      OP_AND:  wdata = a & b;
      OP_OR:   wdata = a | b;
      OP_XOR:  wdata = a ^ b;
      OP_LDI:  wdata = imm;
      OP_XCHG: wdata = b;
      default: wdata = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - control sequencer for a dual-read 4x16 register file
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ABITS = ABITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [ABITS-1:0] op_dst,
  input  logic [ABITS-1:0] op_src,
  input  logic [WIDTH-1:0] op_imm,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic [ABITS-1:0] rf_num1,
  output logic [ABITS-1:0] rf_num2,
  output logic [1:0]       rf_write,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic [WIDTH-1:0] rf_rdata1,
  input  logic [WIDTH-1:0] rf_rdata2
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] READ = ST_READ;
  localparam logic [1:0] WR1  = ST_WR1;
  localparam logic [1:0] WR2  = ST_WR2;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [ABITS-1:0] dst_q;
  logic [ABITS-1:0] src_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_wdata;
  logic             alu_carry;
  logic             accept;

  assign op_ready = (state == IDLE);
  assign accept   = op_valid && op_ready;

  seq_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .imm   (imm_q),
    .wdata (alu_wdata),
    .carry (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      op_q   <= '0;
      dst_q  <= '0;
      src_q  <= '0;
      imm_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op_code;
            dst_q <= op_dst;
            src_q <= op_src;
            imm_q <= op_imm;
            state <= (op_code == OP_LDI) ? WR1 : READ;
          end
        end
        READ: begin
          a_q   <= rf_rdata1;
          b_q   <= rf_rdata2;
          state <= WR1;
        end
        WR1: begin
          result <= alu_wdata;
          if (is_alu_op(op_q)) begin
            flag_z <= (alu_wdata == '0);
            flag_c <= alu_carry;
          end
          if (op_q == OP_XCHG) begin
            state <= WR2;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        WR2: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads and writes live in disjoint states, so the file never sees both at once.
  always_comb begin
    rf_num1  = '0;
    rf_num2  = '0;
    rf_write = 2'b00;
    rf_wdata = '0;
    case (state)
      READ: begin
        rf_num1 = dst_q;
        rf_num2 = src_q;
      end
      WR1: begin
        rf_num1  = dst_q;
        rf_write = 2'b01;
        rf_wdata = alu_wdata;
      end
      WR2: begin
        rf_num2  = src_q;
        rf_write = 2'b10;
        rf_wdata = a_q;
      end
      default: ;
    endcase
    if (rst) rf_write = 2'b00;
  end

endmodule
